morse_key_decoder: RTL and testbench
====================================

// Module: morse_key_decoder
// PURPOSE
//  - Receive side of the Morse path: samples the operator key button and times each press and gap.
//  - Classifies each press as a dot or a dash and assembles the elements into a letter.
//  - Emits the ASCII code of the letter as a one-cycle strobe to the display/character buffer.
//  - Active only when the mode switch selects decode (enable=1); encode mode leaves it idle.
// PARAMETERS
//  DEB_CYCLES       4       cycles key must be stable before a debounced edge is accepted
//  TICK_DIV         10      clk cycles per Morse time unit (real board: ~6_000_000)
//  DOT_MAX_UNITS    2       press shorter than this many units = dot, else dash
//  LETTER_GAP_UNITS 3       release gap (units) that closes a letter
//  WORD_GAP_UNITS   7       release gap (units) that emits one word space
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  enable     in   1  decode mode select (from mode switch, synchronous to clk)
//  key_in     in   1  raw key button, asynchronous, 1=pressed
//  elem_valid out  1  one-cycle strobe: element classified
//  elem_dash  out  1  element type, qualified by elem_valid (0=dot, 1=dash)
//  char_valid out  1  one-cycle strobe: character ready
//  char_code  out  8  ASCII code, qualified by char_valid
//  sym_len    out  3  elements in the current letter so far (0..5), for live display
//  overflow   out  1  sticky: >5 elements in the current letter; cleared on the next char_valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0; FSM=IDLE; counters, shift buffer and synchronisers cleared.
//  - Input path
//    - key_in passes a 2-flop synchroniser, then the debouncer.
//    - Debounced level changes only after DEB_CYCLES consecutive equal synced samples.
//  - Timing
//    - Tick counter divides clk by TICK_DIV and restarts at every debounced edge.
//    - Unit counter (4 bit) counts ticks since the last edge, saturating at 15.
//  - FSM IDLE: wait for debounced press -> MARK; clear units. sym_len=0.
//  - FSM MARK: count units while pressed. On debounced release:
//    - Classify: dash if units>=DOT_MAX_UNITS, else dot.
//    - Pulse elem_valid with elem_dash on the cycle after the release edge.
//    - Shift the element into bits[4:0] at index sym_len (first element = bit 0); sym_len++.
//    - If sym_len was already 5: set overflow, drop the element, sym_len stays 5.
//    - Go to SPACE; clear units.
//  - FSM SPACE: count units while released.
//    - Press before LETTER_GAP_UNITS -> MARK (same letter).
//    - units reaches LETTER_GAP_UNITS -> EMIT.
//  - FSM EMIT (1 cycle):
//    - char_valid=1; char_code=LUT(sym_len,bits), or 0x3F '?' if unmapped or overflow.
//    - Clear buffer, sym_len and overflow; -> GAP.
//  - FSM GAP: still released.
//    - units reaches WORD_GAP_UNITS: one char_valid with 0x20, then -> IDLE.
//    - Press before that -> MARK, no space emitted.
//    - Only one space per gap, however long the gap is.
//  - LUT covers A-Z (uppercase ASCII) and 0-9; every other length/pattern maps to '?'.
//  - Press/release edge landing on the same cycle the gap threshold hits: threshold wins.
//    - EMIT happens first; the edge is taken from the next state on the following cycle.
//    - Debounced edges are levels, so none are lost.
//  - enable=0 (checked every cycle, highest priority after reset):
//    - FSM->IDLE; buffer, sym_len, overflow, counters cleared; no strobes.
//    - A partial letter is discarded.
//    - Synchroniser/debouncer keep running.
//    - After enable returns to 1 while the key is held, wait for release before leaving IDLE.
//  - Strobes never overlap: at most one of elem_valid/char_valid per cycle.
// STRUCTURE
//  - Shared header morse_defs.vh:
//    - FSM state encodings: IDLE, MARK, SPACE, EMIT, GAP.
//    - ASCII constants: '?'=8'h3F, ' '=8'h20.
//    - MAX_ELEMS=5.
//  - Sub-module morse_lut: combinational {len[2:0],bits[4:0]} -> ascii[7:0].
//    - Reusable in reverse by the encoder's table check.
//  - Synchroniser, debouncer, tick/unit counters and FSM are inline.
// TESTING (DEB_CYCLES=4, TICK_DIV=10, DOT=2, LETTER=3, WORD=7)
//  - Press 10 cycles, release 40 cycles -> elem_valid dot; char_valid 'E'=0x45.
//    - sym_len returns to 0 after char_valid.
//  - dot, dash(press 30 cycles), 10-cycle gap between, then 40-cycle gap -> 'A'=0x41.
//  - Gap after the letter held 100 cycles -> 0x45 then exactly one 0x20, then IDLE.
//  - Six dots with 10-cycle gaps -> overflow=1 after the 6th; char_code=0x3F; overflow then 0.
//  - 2-cycle glitch pulses on key_in -> no elem_valid.
//    - Drop enable mid-letter -> no char_valid; next letter decodes clean.
//  - rst_n low during MARK -> all outputs 0 immediately.
//    - After release and a fresh press, 'T'=0x54 decodes normally.

Source files
------------

// File: rtl/morse_key_decoder_pkg.sv
// rtl/morse_key_decoder_pkg.sv - shared FSM states and character constants for the Morse decoder
package morse_key_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_EMIT,
        ST_GAP
    } state_e;

    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [2:0] MAX_ELEMS   = 3'd5;

endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - {element count, element bits} to ASCII; bit 0 is the first element, 1 = dash
module morse_lut
    import morse_key_decoder_pkg::*;
(
    input  logic [2:0] len,
    input  logic [4:0] bits,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_QMARK;
        case ({len, bits})
            8'h20: ascii = 8'h45; // E
            8'h21: ascii = 8'h54; // T
            8'h40: ascii = 8'h49; // I
            8'h41: ascii = 8'h4E; // N
            8'h42: ascii = 8'h41; // A
            8'h43: ascii = 8'h4D; // M
            8'h60: ascii = 8'h53; // S
            8'h61: ascii = 8'h44; // D
            8'h62: ascii = 8'h52; // R
            8'h63: ascii = 8'h47; // G
            8'h64: ascii = 8'h55; // U
            8'h65: ascii = 8'h4B; // K
            8'h66: ascii = 8'h57; // W
            8'h67: ascii = 8'h4F; // O
            8'h80: ascii = 8'h48; // H
            8'h81: ascii = 8'h42; // B
            8'h82: ascii = 8'h4C; // L
            8'h83: ascii = 8'h5A; // Z
            8'h84: ascii = 8'h46; // F
            8'h85: ascii = 8'h43; // C
            8'h86: ascii = 8'h50; // P
            8'h88: ascii = 8'h56; // V
            8'h89: ascii = 8'h58; // X
            8'h8B: ascii = 8'h51; // Q
            8'h8D: ascii = 8'h59; // Y
            8'h8E: ascii = 8'h4A; // J
            8'hA0: ascii = 8'h35; // 5
            8'hA1: ascii = 8'h36; // 6
            8'hA3: ascii = 8'h37; // 7
            8'hA7: ascii = 8'h38; // 8
            8'hAF: ascii = 8'h39; // 9
            8'hBF: ascii = 8'h30; // 0
            8'hBE: ascii = 8'h31; // 1
            8'hBC: ascii = 8'h32; // 2
            8'hB8: ascii = 8'h33; // 3
            8'hB0: ascii = 8'h34; // 4
            default: ascii = ASCII_QMARK;
        endcase
    end

endmodule

// File: rtl/morse_key_decoder.sv
// rtl/morse_key_decoder.sv - key synchroniser, debouncer, unit timing and letter-assembly FSM
module morse_key_decoder
    import morse_key_decoder_pkg::*;
#(
    parameter int DEB_CYCLES       = 4,
    parameter int TICK_DIV         = 10,
    parameter int DOT_MAX_UNITS    = 2,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       key_in,
    output logic       elem_valid,
    output logic       elem_dash,
    output logic       char_valid,
    output logic [7:0] char_code,
    output logic [2:0] sym_len,
    output logic       overflow
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d, sync2_q, sync2_d;
    logic               deb_q, deb_d, armed_q, armed_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [3:0]         units_q, units_d;
    logic [4:0]         bits_q, bits_d;
    logic [2:0]         sym_len_q, sym_len_d;
    logic               overflow_q, overflow_d;
    logic               elem_valid_q, elem_valid_d, elem_dash_q, elem_dash_d;
    logic               char_valid_q, char_valid_d;
    logic [7:0]         char_code_q, char_code_d;
    logic [7:0]         lut_ascii;
    logic               clr_units;

    morse_lut u_lut (
        .len   (sym_len_q),
        .bits  (bits_q),
        .ascii (lut_ascii)
    );

    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) deb_d = sync2_q;
            else                       deb_cnt_d = deb_cnt_q + 1'b1;
        end
        // A press already held when decode mode is entered must be released first.
        armed_d = ~deb_q | (armed_q & enable);
    end

    always_comb begin
        state_d      = state_q;
        bits_d       = bits_q;
        sym_len_d    = sym_len_q;
        overflow_d   = overflow_q;
        elem_valid_d = 1'b0;
        elem_dash_d  = 1'b0;
        char_valid_d = 1'b0;
        char_code_d  = '0;
        clr_units    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr_units = 1'b1;
                if (deb_q && armed_q) state_d = ST_MARK;
            end
            ST_MARK: begin
                if (!deb_q) begin
                    elem_valid_d = 1'b1;
                    elem_dash_d  = (units_q >= 4'(DOT_MAX_UNITS));
                    if (sym_len_q == MAX_ELEMS) begin
                        overflow_d = 1'b1;
                    end else begin
                        bits_d    = bits_q | (5'(elem_dash_d) << sym_len_q);
                        sym_len_d = sym_len_q + 3'd1;
                    end
                    state_d   = ST_SPACE;
                    clr_units = 1'b1;
                end
            end
            ST_SPACE: begin
                if (units_q >= 4'(LETTER_GAP_UNITS)) begin
                    state_d = ST_EMIT;
                end else if (deb_q) begin
                    state_d   = ST_MARK;
                    clr_units = 1'b1;
                end
            end
            ST_EMIT: begin
                char_valid_d = 1'b1;
                char_code_d  = overflow_q ? ASCII_QMARK : lut_ascii;
                bits_d       = '0;
                sym_len_d    = '0;
                overflow_d   = 1'b0;
                state_d      = ST_GAP;
            end
            ST_GAP: begin
                if (units_q >= 4'(WORD_GAP_UNITS)) begin
                    char_valid_d = 1'b1;
                    char_code_d  = ASCII_SPACE;
                    state_d      = ST_IDLE;
                end else if (deb_q) begin
                    state_d   = ST_MARK;
                    clr_units = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d      = ST_IDLE;
            bits_d       = '0;
            sym_len_d    = '0;
            overflow_d   = 1'b0;
            elem_valid_d = 1'b0;
            elem_dash_d  = 1'b0;
            char_valid_d = 1'b0;
            char_code_d  = '0;
            clr_units    = 1'b1;
        end

        tick_d  = tick_q + 1'b1;
        units_d = units_q;
        if (clr_units) begin
            tick_d  = '0;
            units_d = '0;
        end else if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            units_d = (units_q == 4'd15) ? units_q : units_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_q        <= 1'b0;
            deb_cnt_q    <= '0;
            armed_q      <= 1'b0;
            tick_q       <= '0;
            units_q      <= '0;
            bits_q       <= '0;
            sym_len_q    <= '0;
            overflow_q   <= 1'b0;
            elem_valid_q <= 1'b0;
            elem_dash_q  <= 1'b0;
            char_valid_q <= 1'b0;
            char_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            armed_q      <= armed_d;
            tick_q       <= tick_d;
            units_q      <= units_d;
            bits_q       <= bits_d;
            sym_len_q    <= sym_len_d;
            overflow_q   <= overflow_d;
            elem_valid_q <= elem_valid_d;
            elem_dash_q  <= elem_dash_d;
            char_valid_q <= char_valid_d;
            char_code_q  <= char_code_d;
        end
    end

    assign elem_valid = elem_valid_q;
    assign elem_dash  = elem_dash_q;
    assign char_valid = char_valid_q;
    assign char_code  = char_code_q;
    assign sym_len    = sym_len_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// tb/tb_morse_key_decoder.sv - directed self-checking bench for morse_key_decoder
module tb_morse_key_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       key_in = 1'b0;
    logic       elem_valid, elem_dash, char_valid, overflow;
    logic [7:0] char_code;
    logic [2:0] sym_len;

    int vectors = 0;
    int miscompares = 0;
    int overlap_cnt = 0;
    logic       elem_q[$];
    logic [7:0] char_q[$];

    morse_key_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .key_in     (key_in),
        .elem_valid (elem_valid),
        .elem_dash  (elem_dash),
        .char_valid (char_valid),
        .char_code  (char_code),
        .sym_len    (sym_len),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (elem_valid) elem_q.push_back(elem_dash);
        if (char_valid) char_q.push_back(char_code);
        if (elem_valid && char_valid) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic level, input int n);
        key_in = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".elem_valid"}, 32'(elem_valid), 0);
        check({tag, ".elem_dash"},  32'(elem_dash),  0);
        check({tag, ".char_valid"}, 32'(char_valid), 0);
        check({tag, ".char_code"},  32'(char_code),  0);
        check({tag, ".sym_len"},    32'(sym_len),    0);
        check({tag, ".overflow"},   32'(overflow),   0);
    endtask

    task automatic clear_logs();
        elem_q.delete();
        char_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single dot, then a long gap: 'E' followed by exactly one word space.
        clear_logs();
        hold(1'b1, 10);
        hold(1'b0, 15);
        check("E.sym_len_mid", 32'(sym_len), 1);
        hold(1'b0, 185);
        check("E.sym_len_end", 32'(sym_len), 0);
        check("E.n_elem", elem_q.size(), 1);
        if (elem_q.size() == 1) check("E.elem0", 32'(elem_q[0]), 0);
        check("E.n_char", char_q.size(), 2);
        if (char_q.size() == 2) begin
            check("E.char0", 32'(char_q[0]), 32'h45);
            check("E.char1", 32'(char_q[1]), 32'h20);
        end

        // Dot, dash, 40-cycle gap, then a lone dash: 'A' 'T' and a single space.
        clear_logs();
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 30);
        hold(1'b0, 40);
        hold(1'b1, 30);
        hold(1'b0, 200);
        check("AT.n_elem", elem_q.size(), 3);
        if (elem_q.size() == 3) begin
            check("AT.elem0", 32'(elem_q[0]), 0);
            check("AT.elem1", 32'(elem_q[1]), 1);
            check("AT.elem2", 32'(elem_q[2]), 1);
        end
        check("AT.n_char", char_q.size(), 3);
        if (char_q.size() == 3) begin
            check("AT.char0", 32'(char_q[0]), 32'h41);
            check("AT.char1", 32'(char_q[1]), 32'h54);
            check("AT.char2", 32'(char_q[2]), 32'h20);
        end

        // Five dots is the longest legal letter: '5'.
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        hold(1'b0, 190);
        check("five.n_char", char_q.size(), 2);
        if (char_q.size() == 2) check("five.char0", 32'(char_q[0]), 32'h35);

        // Six dots overflows the buffer and decodes as '?'.
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        hold(1'b1, 10);
        hold(1'b0, 15);
        check("ovf.overflow_set", 32'(overflow), 1);
        check("ovf.sym_len_sat", 32'(sym_len), 5);
        hold(1'b0, 185);
        check("ovf.overflow_clr", 32'(overflow), 0);
        check("ovf.n_elem", elem_q.size(), 6);
        check("ovf.n_char", char_q.size(), 2);
        if (char_q.size() == 2) check("ovf.char0", 32'(char_q[0]), 32'h3F);

        // Glitches shorter than the debounce window are ignored.
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 6);
        end
        hold(1'b0, 150);
        check("glitch.n_elem", elem_q.size(), 0);
        check("glitch.n_char", char_q.size(), 0);

        // Dropping enable mid-letter discards the partial letter.
        clear_logs();
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 15);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("dis.sym_len", 32'(sym_len), 0);
        repeat (15) @(negedge clk);
        enable = 1'b1;
        hold(1'b0, 150);
        check("dis.n_char", char_q.size(), 0);
        clear_logs();
        hold(1'b1, 30);
        hold(1'b0, 200);
        check("dis.next_n_elem", elem_q.size(), 1);
        check("dis.next_n_char", char_q.size(), 2);
        if (char_q.size() == 2) check("dis.next_char0", 32'(char_q[0]), 32'h54);

        // Key held across a disable window is not decoded once enable returns.
        clear_logs();
        hold(1'b1, 10);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        hold(1'b1, 30);
        hold(1'b0, 150);
        check("held.n_elem", elem_q.size(), 0);
        check("held.n_char", char_q.size(), 0);

        // Asynchronous reset during a press clears outputs before the next clock edge.
        clear_logs();
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 15);
        check("rst.sym_len_pre", 32'(sym_len), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        key_in = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 20);
        clear_logs();
        hold(1'b1, 30);
        hold(1'b0, 200);
        check("rst.n_char", char_q.size(), 2);
        if (char_q.size() == 2) check("rst.char0", 32'(char_q[0]), 32'h54);

        check("strobe_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
